router_data_reg: RTL and testbench

Datapath register stage of the 1x4 router, directly downstream of the router control FSM. It latches the header byte and stages every byte of the packet onto `dout` for the selected output FIFO, driven by the FSM's state strobes. It holds back the byte that arrives while the FIFO is full and replays it after the stall. It accumulates packet parity and returns `parity_done` and `low_packet_valid` to the FSM, and flags `err` on parity mismatch.

---
 rtl/router_pkg.sv | 29 ++
 rtl/router_parity_chk.sv | 59 +++++
 rtl/router_data_reg.sv | 120 ++++++++++++
 tb/tb_router_data_reg.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared router definitions: byte width default, header field layout, FSM state encoding.
// Ports: none (package).
// Optional feature macro used by router blocks: ROUTER_PARITY_CHECK_EN.
package router_pkg;

   localparam int DATA_W_DEF   = 8;
   localparam int ADDR_W       = 2;

   // Header layout: [ADDR_W-1:0] destination port, [DATA_W-1:ADDR_W] payload length.
   localparam int HDR_DEST_LSB = 0;
   localparam int HDR_DEST_MSB = ADDR_W - 1;
   localparam int HDR_LEN_LSB  = ADDR_W;

   typedef enum logic [2:0] {
      DECODE_ADDRESS     = 3'd0,
      LOAD_FIRST_DATA    = 3'd1,
      LOAD_DATA          = 3'd2,
      FIFO_FULL_STATE    = 3'd3,
      LOAD_AFTER_FULL    = 3'd4,
      LOAD_PARITY        = 3'd5,
      CHECK_PARITY_ERROR = 3'd6,
      WAIT_TILL_EMPTY    = 3'd7
   } router_state_e;

   function automatic logic [ADDR_W-1:0] hdr_dest(input logic [DATA_W_DEF-1:0] hdr);
      return hdr[HDR_DEST_MSB:HDR_DEST_LSB];
   endfunction

endpackage

// File: rtl/router_parity_chk.sv
// Packet parity checker: accumulates header/payload XOR, captures the packet parity byte,
// and compares the two once, on the cycle parity_done rises.
// Ports: clk/resetn (sync, active-low); i_clr = detect_add; i_ld_hdr/i_hdr seed the
// accumulator; i_acc_en/i_acc_dat fold a byte in; i_par_ld/i_par_dat capture packet parity;
// i_parity_done from the data register; o_err registered mismatch flag.
module router_parity_chk
   import router_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              i_clr,
   input  logic              i_ld_hdr,
   input  logic [DATA_W-1:0] i_hdr,
   input  logic              i_acc_en,
   input  logic [DATA_W-1:0] i_acc_dat,
   input  logic              i_par_ld,
   input  logic [DATA_W-1:0] i_par_dat,
   input  logic              i_parity_done,
   output logic              o_err
);

   logic [DATA_W-1:0] r_int_par;
   logic [DATA_W-1:0] r_pkt_par;
   logic              r_pd_q;
   logic              r_err;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_int_par <= '0;
         r_pkt_par <= '0;
         r_pd_q    <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_pd_q <= i_parity_done;

         if (i_clr)
            r_int_par <= '0;
         else if (i_ld_hdr)
            r_int_par <= i_hdr;
         else if (i_acc_en)
            r_int_par <= r_int_par ^ i_acc_dat;

         if (i_par_ld)
            r_pkt_par <= i_par_dat;

         // Compare exactly once per packet: both registers settled on the edge
         // that raised parity_done, so they are final here.
         if (i_parity_done && !r_pd_q)
            r_err <= (r_int_par != r_pkt_par);
         else if (i_clr)
            r_err <= 1'b0;
      end
   end

   assign o_err = r_err;

endmodule

// File: rtl/router_data_reg.sv
// Router datapath register stage: latches the header, stages packet bytes onto dout for
// the selected output FIFO, holds the byte arriving during a FIFO-full stall and replays it
// in LOAD_AFTER_FULL, and reports parity_done / low_packet_valid / err to the control FSM.
// Ports: clk, resetn (sync, active-low); pkt_valid, data_in, fifo_full from source/FIFO;
// detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg FSM strobes;
// dout, parity_done, low_packet_valid, err outputs (all registered).
// Optional macro ROUTER_PARITY_CHECK_EN: when undefined the parity checker is absent
// and err is tied 0.
module router_data_reg
   import router_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              pkt_valid,
   input  logic [DATA_W-1:0] data_in,
   input  logic              fifo_full,
   input  logic              detect_add,
   input  logic              lfd_state,
   input  logic              ld_state,
   input  logic              laf_state,
   input  logic              full_state,
   input  logic              rst_int_reg,
   output logic [DATA_W-1:0] dout,
   output logic              parity_done,
   output logic              low_packet_valid,
   output logic              err
);

   logic [DATA_W-1:0] r_hdr_byte;
   logic [DATA_W-1:0] r_hold_byte;
   logic              r_hold_is_par;
   logic [DATA_W-1:0] r_dout;
   logic              r_parity_done;
   logic              r_low_pkt_valid;

   logic              w_ld_ok;
   logic              w_par_ld;

   // A LOAD_DATA byte is accepted only when the FIFO can take it.
   assign w_ld_ok  = ld_state && !fifo_full;
   // Packet parity arrives either directly or replayed from the stall hold register.
   assign w_par_ld = (w_ld_ok && !pkt_valid) || (laf_state && r_hold_is_par);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_hdr_byte      <= '0;
         r_hold_byte     <= '0;
         r_hold_is_par   <= 1'b0;
         r_dout          <= '0;
         r_parity_done   <= 1'b0;
         r_low_pkt_valid <= 1'b0;
      end else begin
         if (detect_add && pkt_valid)
            r_hdr_byte <= data_in;

         // The byte on data_in when the FIFO fills would otherwise be lost.
         if (ld_state && fifo_full) begin
            r_hold_byte   <= data_in;
            r_hold_is_par <= ~pkt_valid;
         end

         if (lfd_state)
            r_dout <= r_hdr_byte;
         else if (w_ld_ok)
            r_dout <= data_in;       // payload and parity byte both forwarded
         else if (laf_state)
            r_dout <= r_hold_byte;

         if (w_par_ld)
            r_parity_done <= 1'b1;
         else if (detect_add)
            r_parity_done <= 1'b0;

         if (rst_int_reg || detect_add)
            r_low_pkt_valid <= 1'b0;
         else if (ld_state && !pkt_valid)
            r_low_pkt_valid <= 1'b1;
      end
   end

   assign dout             = r_dout;
   assign parity_done      = r_parity_done;
   assign low_packet_valid = r_low_pkt_valid;

`ifdef ROUTER_PARITY_CHECK_EN
   logic              w_acc_en;
   logic [DATA_W-1:0] w_acc_dat;
   logic [DATA_W-1:0] w_par_dat;

   // Header is seeded by lfd_state; each payload byte folds in once, either when
   // accepted directly or when replayed after a stall (never both).
   assign w_acc_en  = (w_ld_ok && pkt_valid) || (laf_state && !r_hold_is_par);
   assign w_acc_dat = (w_ld_ok && pkt_valid) ? data_in : r_hold_byte;
   assign w_par_dat = (w_ld_ok && !pkt_valid) ? data_in : r_hold_byte;

   router_parity_chk #(.DATA_W(DATA_W)) u_parity_chk (
      .clk           (clk),
      .resetn        (resetn),
      .i_clr         (detect_add),
      .i_ld_hdr      (lfd_state),
      .i_hdr         (r_hdr_byte),
      .i_acc_en      (w_acc_en),
      .i_acc_dat     (w_acc_dat),
      .i_par_ld      (w_par_ld),
      .i_par_dat     (w_par_dat),
      .i_parity_done (r_parity_done),
      .o_err         (err)
   );
`else
   assign err = 1'b0;
`endif

   // While the FSM sits in FIFO_FULL_STATE the FIFO write data must not move.
   a_dout_stable_in_full : assert property (
      @(posedge clk) disable iff (!resetn) full_state |=> $stable(dout)
   );

endmodule

// File: tb/tb_router_data_reg.sv
// Bench for router_data_reg: table-driven packet sequences; expected dout bytes are
// queued when each strobe is driven and popped one cycle later; flag outputs are
// checked inline at the points where each scenario defines them.
module tb_router_data_reg;

   localparam int W = 8;
`ifdef ROUTER_PARITY_CHECK_EN
   localparam logic PAR_EN = 1'b1;
`else
   localparam logic PAR_EN = 1'b0;
`endif

   // Strobe encodings {detect_add, lfd, ld, laf, full_state, rst_int_reg}
   localparam logic [5:0] S_NONE = 6'b000000;
   localparam logic [5:0] S_DA   = 6'b100000;
   localparam logic [5:0] S_LFD  = 6'b010000;
   localparam logic [5:0] S_LD   = 6'b001000;
   localparam logic [5:0] S_LAF  = 6'b000100;
   localparam logic [5:0] S_FS   = 6'b000010;
   localparam logic [5:0] S_RI   = 6'b000001;

   typedef struct {
      logic [5:0]   st;
      logic         pv;
      logic         full;
      logic [W-1:0] d;
      logic         ev;
      logic [W-1:0] e;
   } vec_t;

   logic         clk = 1'b0;
   logic         resetn;
   logic         pkt_valid;
   logic [W-1:0] data_in;
   logic         fifo_full;
   logic         detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
   logic [W-1:0] dout;
   logic         parity_done, low_packet_valid, err;

   int           n_chk  = 0;
   int           n_fail = 0;
   vec_t         seq[$];
   logic [W-1:0] sb_q[$];
   logic [W-1:0] exp_b;

   always #5 clk = ~clk;

   router_data_reg #(.DATA_W(W)) dut (
      .clk              (clk),
      .resetn           (resetn),
      .pkt_valid        (pkt_valid),
      .data_in          (data_in),
      .fifo_full        (fifo_full),
      .detect_add       (detect_add),
      .lfd_state        (lfd_state),
      .ld_state         (ld_state),
      .laf_state        (laf_state),
      .full_state       (full_state),
      .rst_int_reg      (rst_int_reg),
      .dout             (dout),
      .parity_done      (parity_done),
      .low_packet_valid (low_packet_valid),
      .err              (err)
   );

   task automatic add(input logic [5:0] st, input logic pv, input logic full,
                      input logic [W-1:0] d, input logic ev, input logic [W-1:0] e);
      vec_t t;
      t.st = st; t.pv = pv; t.full = full; t.d = d; t.ev = ev; t.e = e;
      seq.push_back(t);
   endtask

   // Drive one vector for one clock; queue its expected dout for the next sample point.
   task automatic apply(input vec_t v);
      {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg} = v.st;
      pkt_valid = v.pv;
      fifo_full = v.full;
      data_in   = v.d;
      if (v.ev) sb_q.push_back(v.e);
      @(posedge clk);
      #1;
      {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg} = S_NONE;
      fifo_full = 1'b0;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg} = S_NONE;
      pkt_valid = 1'b0; fifo_full = 1'b0; data_in = 8'h5A;
      repeat (2) @(posedge clk);
      #1;
      n_chk++; if (dout !== 8'h00) begin n_fail++; $display("FAIL reset dout: got %h want 00", dout); end
      n_chk++; if (parity_done !== 1'b0) begin n_fail++; $display("FAIL reset parity_done: got %b want 0", parity_done); end
      n_chk++; if (low_packet_valid !== 1'b0) begin n_fail++; $display("FAIL reset lpv: got %b want 0", low_packet_valid); end
      n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset err: got %b want 0", err); end
      resetn = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_nominal();
      seq.delete();
      add(S_DA,  1, 0, 8'h0D, 0, 8'h00);
      add(S_LFD, 1, 0, 8'h00, 1, 8'h0D);
      add(S_LD,  1, 0, 8'h11, 1, 8'h11);
      add(S_LD,  1, 0, 8'h22, 1, 8'h22);
      add(S_LD,  1, 0, 8'h33, 1, 8'h33);
      add(S_LD,  0, 0, 8'h0D, 1, 8'h0D);
      foreach (seq[i]) begin
         apply(seq[i]);
         if (sb_q.size() != 0) begin
            exp_b = sb_q.pop_front(); n_chk++;
            if (dout !== exp_b) begin n_fail++; $display("FAIL nominal dout[%0d]: got %h want %h", i, dout, exp_b); end
         end
      end
      n_chk++; if (parity_done !== 1'b1) begin n_fail++; $display("FAIL nominal parity_done: got %b want 1", parity_done); end
      seq.delete();
      add(S_NONE, 0, 0, 8'h00, 0, 8'h00);
      apply(seq[0]);
      n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL nominal err: got %b want 0", err); end
      n_chk++; if (low_packet_valid !== 1'b1) begin n_fail++; $display("FAIL nominal lpv: got %b want 1", low_packet_valid); end
   endtask

   task automatic test_parity_error();
      seq.delete();
      add(S_DA,  1, 0, 8'h0D, 0, 8'h00);
      add(S_LFD, 1, 0, 8'h00, 1, 8'h0D);
      add(S_LD,  1, 0, 8'h11, 1, 8'h11);
      add(S_LD,  1, 0, 8'h22, 1, 8'h22);
      add(S_LD,  1, 0, 8'h33, 1, 8'h33);
      add(S_LD,  0, 0, 8'h0E, 1, 8'h0E);
      foreach (seq[i]) begin
         apply(seq[i]);
         if (sb_q.size() != 0) begin
            exp_b = sb_q.pop_front(); n_chk++;
            if (dout !== exp_b) begin n_fail++; $display("FAIL perr dout[%0d]: got %h want %h", i, dout, exp_b); end
         end
      end
      n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL perr err_early: got %b want 0", err); end
      seq.delete();
      add(S_NONE, 0, 0, 8'h00, 0, 8'h00);
      add(S_DA,   1, 0, 8'h0D, 0, 8'h00);
      apply(seq[0]);
      n_chk++; if (err !== PAR_EN) begin n_fail++; $display("FAIL perr err_set: got %b want %b", err, PAR_EN); end
      apply(seq[1]);
      n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL perr err_clear: got %b want 0", err); end
      n_chk++; if (parity_done !== 1'b0) begin n_fail++; $display("FAIL perr pd_clear: got %b want 0", parity_done); end
   endtask

   task automatic test_stall_payload();
      seq.delete();
      add(S_DA,  1, 0, 8'h0D, 0, 8'h00);
      add(S_LFD, 1, 0, 8'h00, 1, 8'h0D);
      add(S_LD,  1, 0, 8'h11, 1, 8'h11);
      add(S_LD,  1, 1, 8'h22, 1, 8'h11);
      add(S_FS,  1, 1, 8'h22, 1, 8'h11);
      add(S_FS,  1, 1, 8'h22, 1, 8'h11);
      add(S_LAF, 1, 0, 8'h22, 1, 8'h22);
      add(S_LD,  1, 0, 8'h33, 1, 8'h33);
      add(S_LD,  0, 0, 8'h0D, 1, 8'h0D);
      add(S_NONE,0, 0, 8'h00, 0, 8'h00);
      foreach (seq[i]) begin
         apply(seq[i]);
         if (sb_q.size() != 0) begin
            exp_b = sb_q.pop_front(); n_chk++;
            if (dout !== exp_b) begin n_fail++; $display("FAIL stall_pl dout[%0d]: got %h want %h", i, dout, exp_b); end
         end
      end
      n_chk++; if (parity_done !== 1'b1) begin n_fail++; $display("FAIL stall_pl parity_done: got %b want 1", parity_done); end
      n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL stall_pl err: got %b want 0", err); end
   endtask

   task automatic test_stall_parity();
      seq.delete();
      add(S_DA,  1, 0, 8'h0D, 0, 8'h00);
      add(S_LFD, 1, 0, 8'h00, 1, 8'h0D);
      add(S_LD,  1, 0, 8'h11, 1, 8'h11);
      add(S_LD,  1, 0, 8'h22, 1, 8'h22);
      add(S_LD,  1, 0, 8'h33, 1, 8'h33);
      add(S_LD,  0, 1, 8'h0D, 1, 8'h33);
      add(S_FS,  0, 1, 8'h0D, 1, 8'h33);
      foreach (seq[i]) begin
         apply(seq[i]);
         if (sb_q.size() != 0) begin
            exp_b = sb_q.pop_front(); n_chk++;
            if (dout !== exp_b) begin n_fail++; $display("FAIL stall_par dout[%0d]: got %h want %h", i, dout, exp_b); end
         end
      end
      n_chk++; if (parity_done !== 1'b0) begin n_fail++; $display("FAIL stall_par pd_early: got %b want 0", parity_done); end
      seq.delete();
      add(S_LAF, 0, 0, 8'h00, 1, 8'h0D);
      add(S_NONE,0, 0, 8'h00, 0, 8'h00);
      apply(seq[0]);
      exp_b = sb_q.pop_front(); n_chk++;
      if (dout !== exp_b) begin n_fail++; $display("FAIL stall_par dout_laf: got %h want %h", dout, exp_b); end
      n_chk++; if (parity_done !== 1'b1) begin n_fail++; $display("FAIL stall_par pd_laf: got %b want 1", parity_done); end
      apply(seq[1]);
      n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL stall_par err: got %b want 0", err); end
   endtask

   task automatic test_reset_mid_packet();
      seq.delete();
      add(S_DA,  1, 0, 8'h0D, 0, 8'h00);
      add(S_LFD, 1, 0, 8'h00, 1, 8'h0D);
      add(S_LD,  1, 0, 8'h11, 1, 8'h11);
      foreach (seq[i]) begin
         apply(seq[i]);
         if (sb_q.size() != 0) begin
            exp_b = sb_q.pop_front(); n_chk++;
            if (dout !== exp_b) begin n_fail++; $display("FAIL rst_mid dout[%0d]: got %h want %h", i, dout, exp_b); end
         end
      end
      seq.delete();
      add(S_LD, 0, 0, 8'h22, 1, 8'h00);
      resetn = 1'b0;
      apply(seq[0]);
      resetn = 1'b1;
      exp_b = sb_q.pop_front(); n_chk++;
      if (dout !== exp_b) begin n_fail++; $display("FAIL rst_mid dout_rst: got %h want %h", dout, exp_b); end
      n_chk++; if (parity_done !== 1'b0) begin n_fail++; $display("FAIL rst_mid pd: got %b want 0", parity_done); end
      n_chk++; if (low_packet_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid lpv: got %b want 0", low_packet_valid); end
      n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_mid err: got %b want 0", err); end
      seq.delete();
      add(S_DA,  1, 0, 8'h05, 0, 8'h00);
      add(S_LFD, 1, 0, 8'h00, 1, 8'h05);
      add(S_LD,  1, 0, 8'hAA, 1, 8'hAA);
      add(S_LD,  0, 0, 8'hAF, 1, 8'hAF);
      add(S_NONE,0, 0, 8'h00, 0, 8'h00);
      foreach (seq[i]) begin
         apply(seq[i]);
         if (sb_q.size() != 0) begin
            exp_b = sb_q.pop_front(); n_chk++;
            if (dout !== exp_b) begin n_fail++; $display("FAIL fresh dout[%0d]: got %h want %h", i, dout, exp_b); end
         end
      end
      n_chk++; if (parity_done !== 1'b1) begin n_fail++; $display("FAIL fresh pd: got %b want 1", parity_done); end
      n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL fresh err: got %b want 0", err); end
   endtask

   task automatic test_low_packet_valid();
      seq.delete();
      add(S_DA,  1, 0, 8'h0D, 0, 8'h00);
      add(S_LFD, 1, 0, 8'h00, 1, 8'h0D);
      add(S_LD,  1, 0, 8'h11, 1, 8'h11);
      foreach (seq[i]) begin
         apply(seq[i]);
         if (sb_q.size() != 0) begin
            exp_b = sb_q.pop_front(); n_chk++;
            if (dout !== exp_b) begin n_fail++; $display("FAIL lpv dout[%0d]: got %h want %h", i, dout, exp_b); end
         end
      end
      n_chk++; if (low_packet_valid !== 1'b0) begin n_fail++; $display("FAIL lpv before_drop: got %b want 0", low_packet_valid); end
      seq.delete();
      add(S_LD,   0, 0, 8'h1C, 1, 8'h1C);
      add(S_NONE, 0, 0, 8'h00, 0, 8'h00);
      add(S_RI,   0, 0, 8'h00, 0, 8'h00);
      apply(seq[0]);
      exp_b = sb_q.pop_front(); n_chk++;
      if (dout !== exp_b) begin n_fail++; $display("FAIL lpv dout_par: got %h want %h", dout, exp_b); end
      n_chk++; if (low_packet_valid !== 1'b1) begin n_fail++; $display("FAIL lpv set: got %b want 1", low_packet_valid); end
      apply(seq[1]);
      n_chk++; if (low_packet_valid !== 1'b1) begin n_fail++; $display("FAIL lpv hold: got %b want 1", low_packet_valid); end
      apply(seq[2]);
      n_chk++; if (low_packet_valid !== 1'b0) begin n_fail++; $display("FAIL lpv clear: got %b want 0", low_packet_valid); end
      n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL lpv err: got %b want 0", err); end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_parity_error();
      test_stall_payload();
      test_stall_parity();
      test_reset_mid_packet();
      test_low_packet_valid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
